// File: rtl/polybius_modified_decrypt.sv
`default_nettype none
// ============================================================================
// Module      : polybius_modified_decrypt
// Description : Streaming Polybius-square decoder. Ciphertext arrives as
//               ASCII digit pairs (row digit, then column digit), with
//               optional space separators. Each completed pair yields one
//               plaintext character BASE_CHAR + (r-1)*GRID + (c-1). Pairs
//               with an out-of-range digit, and pairs cut short by a space,
//               yield an error result.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   GRID       grid side length, 1..9
//   BASE_CHAR  character at row 1, column 1
// Ports
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   in_char holds a ciphertext byte
//   in_char    ASCII digit or space (8'h20)
//   in_ready   byte is accepted this cycle
//   out_valid  out_char/out_err hold a decoded result
//   out_ready  downstream accepts the result this cycle
//   out_char   decoded character, 8'h00 on error
//   out_err    result came from a malformed or truncated pair
//   err_count  saturating count of error results
// ============================================================================
module polybius_modified_decrypt #(
  parameter int         GRID      = 7,
  parameter logic [7:0] BASE_CHAR = 8'h2A
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [7:0] in_char,
  output logic       in_ready,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_char,
  output logic       out_err,
  output logic [7:0] err_count
);

  localparam logic [7:0] c_space    = 8'h20;
  localparam logic [7:0] c_digit_lo = 8'h31;
  localparam logic [7:0] c_digit_hi = 8'(8'h30 + GRID);
  localparam logic [7:0] c_grid     = 8'(GRID);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    ROW  = 1'b1
  } state_t;

  state_t     r_state;
  logic [7:0] r_row;
  logic       r_out_valid;
  logic [7:0] r_out_char;
  logic       r_out_err;
  logic [7:0] r_err_count;

  logic       w_in_xfer;
  logic       w_is_space;
  logic       w_load;
  logic       w_row_ok;
  logic       w_col_ok;
  logic       w_pair_ok;
  logic [7:0] w_row_idx;
  logic [7:0] w_col_idx;
  logic [7:0] w_decoded;

  // The result register is the only buffer: the input may move whenever that
  // register is empty or is being drained on this same edge.
  assign in_ready   = !r_out_valid || out_ready;
  assign w_in_xfer  = in_valid && in_ready;
  assign w_is_space = (in_char == c_space);
  assign w_load     = w_in_xfer && (r_state == ROW);

  assign w_row_ok  = (r_row   >= c_digit_lo) && (r_row   <= c_digit_hi);
  assign w_col_ok  = (in_char >= c_digit_lo) && (in_char <= c_digit_hi);
  // A space as column byte fails w_col_ok, so truncation folds into the
  // same error path as an out-of-range digit.
  assign w_pair_ok = !w_is_space && w_row_ok && w_col_ok;

  // Zero-based grid indices; only meaningful when w_pair_ok. The sum wraps
  // mod 256 by construction of the 8-bit result.
  assign w_row_idx = r_row   - c_digit_lo;
  assign w_col_idx = in_char - c_digit_lo;
  assign w_decoded = BASE_CHAR + (w_row_idx * c_grid) + w_col_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_row       <= 8'h00;
      r_out_valid <= 1'b0;
      r_out_char  <= 8'h00;
      r_out_err   <= 1'b0;
      r_err_count <= 8'h00;
    end else begin
      // Pair tracking
      if (w_in_xfer) begin
        case (r_state)
          IDLE: begin
            if (!w_is_space) begin
              r_row   <= in_char;
              r_state <= ROW;
            end
          end
          ROW: begin
            r_state <= IDLE;
          end
          default: begin
            r_state <= IDLE;
          end
        endcase
      end

      // Result register: a load on the same edge as a drain replaces the
      // result so out_valid stays high without a bubble.
      if (w_load) begin
        r_out_valid <= 1'b1;
        r_out_char  <= w_pair_ok ? w_decoded : 8'h00;
        r_out_err   <= !w_pair_ok;
        if (!w_pair_ok && (r_err_count != 8'hFF)) begin
          r_err_count <= r_err_count + 8'd1;
        end
      end else if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_char  = r_out_char;
  assign out_err   = r_out_err;
  assign err_count = r_err_count;

endmodule
`default_nettype wire

// File: tb/tb_polybius_modified_decrypt.sv
`default_nettype none
// ============================================================================
// Module      : tb_polybius_modified_decrypt
// Description : Self-checking bench for polybius_modified_decrypt with
//               GRID=7, BASE_CHAR='*'. A reference model of the pair
//               decoder is compared against the DUT every cycle; directed
//               scenarios add literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_polybius_modified_decrypt;

  localparam int         G    = 7;
  localparam logic [7:0] BASE = 8'h2A;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] in_char;
  logic       in_ready;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_char;
  logic       out_err;
  logic [7:0] err_count;

  int n_checks = 0;
  int n_fail   = 0;

  polybius_modified_decrypt #(
    .GRID      (G),
    .BASE_CHAR (BASE)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_char   (in_char),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_char  (out_char),
    .out_err   (out_err),
    .err_count (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- model
  logic       m_valid;
  logic [7:0] m_char;
  logic       m_err;
  int         m_cnt;
  logic [7:0] m_held[$];

  function automatic void decode(input logic [7:0] r, input logic [7:0] c,
                                 output logic [7:0] ch, output logic e);
    int ri;
    int ci;
    ri = int'(r) - 48;
    ci = int'(c) - 48;
    if (ri >= 1 && ri <= G && ci >= 1 && ci <= G) begin
      ch = 8'((int'(BASE) + (ri - 1) * G + (ci - 1)) % 256);
      e  = 1'b0;
    end else begin
      ch = 8'h00;
      e  = 1'b1;
    end
  endfunction

  task automatic model_reset();
    m_valid = 1'b0;
    m_char  = 8'h00;
    m_err   = 1'b0;
    m_cnt   = 0;
    m_held.delete();
  endtask

  // Inputs change only just after a rising edge, so values seen at the
  // falling edge are exactly those acting on the next rising edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      model_reset();
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
      chk("rst_err_count", {24'd0, err_count}, 32'd0);
    end else begin
      logic       xin;
      logic       load;
      logic [7:0] nc;
      logic       ne;
      chk("in_ready_rule", {31'd0, in_ready}, {31'd0, (!m_valid || out_ready)});
      chk("out_valid",     {31'd0, out_valid}, {31'd0, m_valid});
      if (m_valid) begin
        chk("out_char", {24'd0, out_char}, {24'd0, m_char});
        chk("out_err",  {31'd0, out_err},  {31'd0, m_err});
      end
      chk("err_count", {24'd0, err_count}, 32'(m_cnt));

      xin  = in_valid && (!m_valid || out_ready);
      load = 1'b0;
      nc   = 8'h00;
      ne   = 1'b0;
      if (xin) begin
        if (m_held.size() == 0) begin
          if (in_char != 8'h20) m_held.push_back(in_char);
        end else begin
          logic [7:0] r;
          r = m_held.pop_front();
          load = 1'b1;
          if (in_char == 8'h20) begin
            nc = 8'h00;
            ne = 1'b1;
          end else begin
            decode(r, in_char, nc, ne);
          end
        end
      end
      if (load) begin
        m_valid = 1'b1;
        m_char  = nc;
        m_err   = ne;
        if (ne && m_cnt < 255) m_cnt++;
      end else if (m_valid && out_ready) begin
        m_valid = 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------- stimulus
  task automatic send(input logic [7:0] b);
    int n;
    bit done;
    in_valid = 1'b1;
    in_char  = b;
    n = 0;
    done = 1'b0;
    while (!done && n < 100) begin
      @(negedge clk);
      done = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: byte %0h not accepted after %0d cycles", b, n);
    end
  endtask

  task automatic pair(input string name, input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] exp_c, input logic exp_e);
    send(a);
    send(b);
    chk({name, "_valid"}, {31'd0, out_valid}, 32'd1);
    chk({name, "_char"},  {24'd0, out_char},  {24'd0, exp_c});
    chk({name, "_err"},   {31'd0, out_err},   {31'd0, exp_e});
  endtask

  function automatic logic [7:0] rand_byte();
    int sel;
    sel = $urandom_range(15);
    if (sel < 2)       return 8'h20;
    else if (sel == 2) return 8'($urandom_range(255));
    else               return 8'(8'h30 + $urandom_range(9));
  endfunction

  task automatic pulse_reset(input int cycles);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    chk("async_out_valid", {31'd0, out_valid}, 32'd0);
    chk("async_out_char",  {24'd0, out_char},  32'd0);
    chk("async_err_count", {24'd0, err_count}, 32'd0);
    chk("async_in_ready",  {31'd0, in_ready},  32'd1);
    repeat (cycles) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_char   = 8'h00;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_in_ready",  {31'd0, in_ready},  32'd1);
    rst_n = 1'b1;

    // Basic decodes
    pair("p11", "1", "1", 8'h2A, 1'b0);
    pair("p43", "4", "3", 8'h41, 1'b0);
    pair("p77", "7", "7", 8'h5A, 1'b0);

    // Out-of-range digits
    pair("p81", "8", "1", 8'h00, 1'b1);
    pair("p10", "1", "0", 8'h00, 1'b1);
    chk("errcnt_2", {24'd0, err_count}, 32'd2);

    // Leading/trailing spaces
    send(" ");
    chk("lead_space_noout", {31'd0, out_valid}, 32'd0);
    pair("p12", "1", "2", 8'h2B, 1'b0);
    send(" ");
    chk("trail_space_noout", {31'd0, out_valid}, 32'd0);

    // Truncated pair then realignment
    pair("trunc", "3", " ", 8'h00, 1'b1);
    chk("errcnt_3", {24'd0, err_count}, 32'd3);
    pair("realign", "1", "2", 8'h2B, 1'b0);

    // Backpressure
    pair("bp43", "4", "3", 8'h41, 1'b0);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_in_ready", {31'd0, in_ready},  32'd0);
      chk("bp_hold",     {24'd0, out_char},  32'h41);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    pair("bp11", "1", "1", 8'h2A, 1'b0);

    // Reset mid-pair discards the row byte
    send("5");
    pulse_reset(2);
    pair("post_rst", "1", "1", 8'h2A, 1'b0);
    for (int i = 0; i < 256; i++) begin
      send("9");
      send("9");
    end
    chk("errcnt_sat", {24'd0, err_count}, 32'hFF);
    chk("sat_err",    {31'd0, out_err},   32'd1);

    // Randomized traffic with random backpressure
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc == 1500) pulse_reset(2);
      in_valid  = ($urandom_range(3) != 0);
      in_char   = rand_byte();
      out_ready = ($urandom_range(2) != 0);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    repeat (3) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, failures so far %0d", n_fail);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/polybius_modified_decrypt.md
POLYBIUS_MODIFIED_DECRYPT -- requirements
Module: polybius_modified_decrypt

Interface
REQ-001 Parameter GRID, default 7, grid side length; legal range 1..9.
REQ-002 Parameter BASE_CHAR, default 8'h2A ('*'), character at grid row 1, column 1.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 in_valid  input  1  in_char holds a valid ciphertext byte.
REQ-006 in_char  input  8  ASCII ciphertext byte: a digit or a space separator (8'h20).
REQ-007 in_ready  output  1  block accepts in_char this cycle.
REQ-008 out_valid  output  1  out_char/out_err hold a decoded result.
REQ-009 out_ready  input  1  downstream accepts the result this cycle.
REQ-010 out_char  output  8  decoded plaintext character; 8'h00 when out_err=1.
REQ-011 out_err  output  1  result comes from a malformed pair.
REQ-012 err_count  output  8  count of error results emitted, saturating.

Function
REQ-013 An input transfer occurs on a rising edge with in_valid=1 and in_ready=1; an output transfer occurs on a rising edge with out_valid=1 and out_ready=1.
REQ-014 in_ready SHALL equal (!out_valid || out_ready), combinationally, in every state.
REQ-015 FSM states: IDLE (no row digit held) and ROW (row digit held); reset state IDLE.
REQ-016 In IDLE, an accepted space is dropped with no output and no state change.
REQ-017 In IDLE, an accepted non-space byte is stored as the row byte and the FSM moves to ROW.
REQ-018 In ROW, an accepted non-space byte is the column byte: a result is loaded and the FSM moves to IDLE.
REQ-019 In ROW, an accepted space loads an error result and moves the FSM to IDLE; this is a truncated pair.
REQ-020 A digit byte is valid when it lies in "1" .. ("0"+GRID), i.e. 8'h31..8'h30+GRID; r and c are the digit values.
REQ-021 If both bytes are valid, out_char SHALL be BASE_CHAR + (r-1)*GRID + (c-1), computed mod 256, with out_err=0.
REQ-022 If either byte is invalid, or the pair is truncated, out_char SHALL be 8'h00 with out_err=1.
REQ-023 Latency: a result loaded at edge N SHALL show out_valid=1 from just after edge N, one cycle after the column byte is presented.
REQ-024 out_valid, out_char and out_err SHALL hold stable while out_valid=1 and out_ready=0.
REQ-025 out_valid clears on an output transfer unless a new result loads on the same edge.
REQ-026 An output transfer and a new load on the same edge SHALL replace the result, keeping out_valid=1 with no bubble.
REQ-027 Sustained throughput SHALL be one result per two input transfers.
REQ-028 err_count SHALL increment by 1 when an error result is loaded, and saturate at 8'hFF.
REQ-029 in_char is ignored whenever no input transfer occurs; no state change without a transfer.

Reset
REQ-030 When rst_n=0, the block SHALL asynchronously clear the FSM to IDLE, the held row byte, out_valid, out_char, out_err and err_count to 0.
REQ-031 While rst_n=0, in_ready SHALL read 1, since out_valid=0.
REQ-032 A reset mid-pair (in ROW) SHALL discard the row byte; the next accepted non-space byte is treated as a row byte.
REQ-033 Reset release SHALL be synchronised externally; the block accepts input on the first edge after release.

Verification
REQ-034 The bench SHALL cover these scenarios with GRID=7, BASE_CHAR=8'h2A, out_ready=1:
- "1","1" -> out_char 8'h2A ('*'), out_err 0; "4","3" -> 8'h41 ('A'); "7","7" -> 8'h5A ('Z').
- "8","1" then "1","0" -> two results, out_char 8'h00, out_err 1, err_count 2.
- " ","1","2"," " -> exactly one result, 8'h2B ('+'); the leading and trailing spaces produce no output.
- "3"," " -> one error result; the next pair "1","2" decodes to 8'h2B, showing realignment.
- Backpressure: out_ready=0 after "4","3" -> in_ready=0, 'A' held stable for 5 cycles; raise out_ready while presenting the next pair "1","1" -> no bubble, then '*'.
- rst_n pulsed low after row byte "5" -> outputs 0 immediately; then "1","1" -> '*'; 256 error pairs -> err_count 8'hFF.
